// File: rtl/i2c_avmm_csr_slave_pkg.sv
// Shared definitions for the I2C-bridge CSR slave: register word indices, flag bits, STATUS fields.
// Byte offset of each register is its word index times four.
package i2c_csr_pkg;

  typedef enum logic [2:0] {
    REG_ID      = 3'd0,
    REG_SCRATCH = 3'd1,
    REG_CTRL    = 3'd2,
    REG_STATUS  = 3'd3,
    REG_MBX     = 3'd4,
    REG_FLAGS   = 3'd5
  } reg_idx_e;

  localparam int FLAG_OVF     = 0;
  localparam int FLAG_BADADDR = 1;
  localparam int FLAG_PROTO   = 2;

  localparam int ST_EMPTY   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_CNT_LSB = 8;

  localparam logic [31:0] DEFAULT_ID_VALUE = 32'h12C0_0001;

  function automatic logic [31:0] be_merge(input logic [31:0] cur, input logic [31:0] wdat,
                                           input logic [3:0] be);
    logic [31:0] res;
    res = cur;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[b*8 +: 8] = wdat[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/i2c_avmm_csr_slave_if.sv
// Avalon-MM transfer signals between the I2C bridge master and the CSR slave.
// Reads return through readdata/readdatavalid; waitrequest stalls the master.
interface i2c_avmm_csr_slave_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic        waitrequest;

  modport master (
    output address, read, write, byteenable, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, read, write, byteenable, writedata,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/i2c_avmm_csr_slave_fifo.sv
// First-word-fall-through FIFO: head visible combinationally, zero-cycle read latency.
// A push into a full FIFO succeeds only with a same-cycle pop; otherwise it is dropped and flagged.
module csr_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_vld,
  input  logic [WIDTH-1:0]             push_dat,
  output logic                         pop_vld,
  input  logic                         pop_rdy,
  output logic [WIDTH-1:0]             pop_dat,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         drop
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             pop, push_ok;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign pop_vld = !empty;
  assign pop     = pop_vld && pop_rdy;
  assign push_ok = push_vld && (!full || pop);
  assign drop    = push_vld && !push_ok;
  assign pop_dat = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/i2c_avmm_csr_slave.sv
// Avalon-MM CSR slave behind the I2C bridge: WAIT_STATES stall cycles per transfer, reads return
// READ_LATENCY cycles after acceptance, writes are byte-enabled; mailbox words stream out valid/ready.
module i2c_avmm_csr_slave
  import i2c_csr_pkg::*;
#(
  parameter int          WAIT_STATES  = 1,
  parameter int          READ_LATENCY = 2,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [31:0] ID_VALUE     = DEFAULT_ID_VALUE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  i2c_avmm_csr_slave_if.slave   avmm,
  output logic [31:0]           ctrl_out,
  output logic [31:0]           mbx_data,
  output logic                  mbx_valid,
  input  logic                  mbx_ready,
  output logic                  irq
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  logic                          req, accept, wr_acc, rd_acc, bad, push_vld;
  logic [2:0]                    idx, flags, flag_set, flag_clr;
  logic [3:0]                    wcnt;
  logic [31:0]                   scratch, ctrl, rd_word;
  logic                          fifo_drop, fifo_full, fifo_empty;
  logic [CW-1:0]                 fifo_cnt;
  logic [READ_LATENCY-1:0]       pipe_vld, in_vld;
  logic [READ_LATENCY-1:0][31:0] pipe_dat, in_dat;

  assign req              = avmm.read | avmm.write;
  assign avmm.waitrequest = req && (wcnt != WS);
  assign accept           = req && !avmm.waitrequest;
  assign wr_acc           = accept && avmm.write;
  assign rd_acc           = accept && avmm.read && !avmm.write;
  assign idx              = avmm.address[4:2];
  assign bad              = (|avmm.address[31:5]) || (|avmm.address[1:0]) || (idx > 3'd5);
  assign push_vld         = wr_acc && !bad && (idx == REG_MBX);
  assign ctrl_out         = ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              wcnt <= '0;
    else if (!req || accept) wcnt <= '0;
    else                     wcnt <= wcnt + 4'd1;
  end

  // Read value reflects state before any write landing in the same cycle.
  always_comb begin
    rd_word = '0;
    if (!bad) begin
      case (reg_idx_e'(idx))
        REG_ID:      rd_word = ID_VALUE;
        REG_SCRATCH: rd_word = scratch;
        REG_CTRL:    rd_word = ctrl;
        REG_STATUS: begin
          rd_word[ST_EMPTY]         = fifo_empty;
          rd_word[ST_FULL]          = fifo_full;
          rd_word[ST_CNT_LSB +: 8]  = 8'(fifo_cnt);
        end
        REG_FLAGS:   rd_word[2:0] = flags;
        default:     rd_word = '0;
      endcase
    end
  end

  always_comb begin
    flag_set               = '0;
    flag_set[FLAG_OVF]     = fifo_drop;
    flag_set[FLAG_BADADDR] = accept && bad;
    flag_set[FLAG_PROTO]   = accept && avmm.read && avmm.write;
    flag_clr               = '0;
    if (wr_acc && !bad && (idx == REG_FLAGS) && avmm.byteenable[0])
      flag_clr = avmm.writedata[2:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scratch <= '0;
      ctrl    <= '0;
      flags   <= '0;
      irq     <= 1'b0;
    end else begin
      if (wr_acc && !bad && (idx == REG_SCRATCH))
        scratch <= be_merge(scratch, avmm.writedata, avmm.byteenable);
      if (wr_acc && !bad && (idx == REG_CTRL))
        ctrl <= be_merge(ctrl, avmm.writedata, avmm.byteenable);
      // Set wins over a simultaneous clear of the same bit.
      flags <= (flags & ~flag_clr) | flag_set;
      irq   <= |(flags & ctrl[2:0]);
    end
  end

  always_comb begin
    in_vld    = '0;
    in_dat    = '0;
    in_vld[0] = rd_acc;
    in_dat[0] = rd_word;
    for (int i = 1; i < READ_LATENCY; i++) begin
      in_vld[i] = pipe_vld[i-1];
      in_dat[i] = pipe_dat[i-1];
    end
  end

  // Stages only load on valid so the final stage holds the last returned word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld <= '0;
      pipe_dat <= '0;
    end else begin
      pipe_vld <= in_vld;
      for (int i = 0; i < READ_LATENCY; i++) begin
        if (in_vld[i]) pipe_dat[i] <= in_dat[i];
      end
    end
  end

  assign avmm.readdatavalid = pipe_vld[READ_LATENCY-1];
  assign avmm.readdata      = pipe_dat[READ_LATENCY-1];

  csr_sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_mbx_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (push_vld),
    .push_dat (avmm.writedata),
    .pop_vld  (mbx_valid),
    .pop_rdy  (mbx_ready),
    .pop_dat  (mbx_data),
    .count    (fifo_cnt),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .drop     (fifo_drop)
  );
endmodule
